// File: rtl/display_mux.sv
// display_mux: time-multiplexed, double-buffered hex driver for N_DIG common-cathode 7-segment digits.
module display_mux #(
    parameter int N_DIG   = 4,
    parameter int CLK_DIV = 50000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       load,
    input  logic [4*N_DIG-1:0]         data,
    input  logic [N_DIG-1:0]           dp,
    input  logic                       blank_lz,
    output logic [6:0]                 seg,
    output logic                       dp_out,
    output logic [N_DIG-1:0]           an,
    output logic [$clog2(N_DIG)-1:0]   digit_idx,
    output logic                       frame_done
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(N_DIG);
    logic [PW-1:0]      r_presc;
    logic [4*N_DIG-1:0] r_pend, r_disp;
    logic [N_DIG-1:0]   r_pend_dp, r_disp_dp;
    logic               w_tick, w_wrap, w_blank;
    logic [IW-1:0]      w_next_idx;
    logic [4*N_DIG-1:0] w_disp_n;
    logic [N_DIG-1:0]   w_dp_n, w_lz;
    logic [3:0]         w_nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h7E;
            4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;
            4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;
            4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;
            4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;
            4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;
            default: hex7 = 7'h47;
        endcase
    endfunction

    assign w_tick     = en && r_presc == PW'(CLK_DIV - 1);
    assign w_wrap     = w_tick && digit_idx == IW'(N_DIG - 1);
    assign w_next_idx = w_wrap ? '0 : digit_idx + IW'(1);
    assign frame_done = w_wrap;
    // The new frame's digit 0 is decoded from the buffer being swapped in, including a same-cycle load.
    assign w_disp_n   = w_wrap ? (load ? data : r_pend) : r_disp;
    assign w_dp_n     = w_wrap ? (load ? dp : r_pend_dp) : r_disp_dp;
    assign w_nib      = w_disp_n[4*w_next_idx +: 4];
    assign w_blank    = blank_lz && w_next_idx != '0 && w_lz[w_next_idx];

    // w_lz[k]: every nibble from the top down to k is zero.
    always_comb begin
        logic z;
        z = 1'b1;
        w_lz = '0;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            z = z && w_disp_n[4*k +: 4] == 4'd0;
            w_lz[k] = z;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            digit_idx <= IW'(N_DIG - 1);
            r_pend    <= '0;
            r_pend_dp <= '0;
            r_disp    <= '0;
            r_disp_dp <= '0;
            seg       <= '0;
            dp_out    <= 1'b0;
            an        <= '0;
        end else begin
            if (load) begin
                r_pend    <= data;
                r_pend_dp <= dp;
            end
            if (w_wrap) begin
                r_disp    <= w_disp_n;
                r_disp_dp <= w_dp_n;
            end
            if (en)
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (!en) begin
                an     <= '0;
                seg    <= '0;
                dp_out <= 1'b0;
            end else if (w_tick) begin
                digit_idx <= w_next_idx;
                an        <= N_DIG'(1) << w_next_idx;
                seg       <= w_blank ? 7'h00 : hex7(w_nib);
                dp_out    <= w_dp_n[w_next_idx];
            end
        end
    end
endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: randomized stimulus against a digit-level reference model of display_mux.
module tb_display_mux;
    localparam int N = 4;
    localparam int D = 4;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;
    int          checks = 0, failures = 0;
    int          cnt, m_idx;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pdp, m_ddp, m_an;
    logic [6:0]  m_seg;
    logic        m_dpo;
    logic [6:0]  segtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clk = ~clk;

    display_mux #(.N_DIG(N), .CLK_DIV(D)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .dp(dp),
        .blank_lz(blank_lz), .seg(seg), .dp_out(dp_out), .an(an),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cnt = 0; m_idx = N - 1;
        m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
        m_an = '0; m_seg = '0; m_dpo = 1'b0;
    endtask

    task automatic check_all();
        chk("an", an, m_an);
        chk("seg", seg, m_seg);
        chk("dp_out", dp_out, m_dpo);
        chk("digit_idx", digit_idx, m_idx);
        chk("frame_done", frame_done, en && cnt == D - 1 && m_idx == N - 1);
    endtask

    // One clock edge of the display: slot timing, frame swap, then decode of the newly selected digit.
    task automatic model_step();
        bit tick, wrap;
        int lead;
        tick = en && cnt == D - 1;
        wrap = tick && m_idx == N - 1;
        if (wrap) begin
            m_disp = load ? data : m_pend;
            m_ddp  = load ? dp : m_pdp;
        end
        if (load) begin
            m_pend = data;
            m_pdp  = dp;
        end
        if (en) cnt = (cnt + 1) % D;
        if (!en) begin
            m_an = '0; m_seg = '0; m_dpo = 1'b0;
        end else if (tick) begin
            m_idx = (m_idx + 1) % N;
            m_an  = 4'(1 << m_idx);
            lead  = 0;
            for (int k = 0; k < N; k++) if (m_disp[4*k +: 4] != 4'd0) lead = k;
            m_seg = (blank_lz && m_idx > lead) ? 7'h00 : segtab[m_disp[4*m_idx +: 4]];
            m_dpo = m_ddp[m_idx];
        end
    endtask

    task automatic rand_inputs();
        en       = $urandom_range(0, 9) != 0;
        load     = $urandom_range(0, 5) == 0;
        blank_lz = 1'($urandom_range(0, 1));
        dp       = 4'($urandom);
        for (int k = 0; k < N; k++)
            data[4*k +: 4] = $urandom_range(0, 1) != 0 ? 4'd0 : 4'($urandom);
    endtask

    // Called at a falling edge: drive, check, let the rising edge happen, advance the model.
    task automatic step(input bit rnd);
        if (rnd) rand_inputs();
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b0);
        data = 16'hFEDC; load = 1'b1;
        step(1'b0);
        load = 1'b0;
        for (int i = 0; i < 40; i++) step(1'b0);
        for (int i = 0; i < 3000; i++) step(1'b1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; load = 1'b0; blank_lz = 1'b0;
        for (int i = 0; i < 30; i++) step(1'b0);
        for (int i = 0; i < 1500; i++) step(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
